mic_frame_writer: RTL and testbench



---
 rtl/mic_frame_pkg.sv | 26 ++
 rtl/mic_frame_writer_valid_edge_sync.sv | 32 +++
 rtl/mic_frame_writer.sv | 217 +++++++++++++++++++++
 tb/tb_mic_frame_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_frame_pkg.sv
// mic_frame_pkg: shared constants and FSM state type for the microphone
// frame writer.
//   SAMPLE_W     - width of one decimated microphone sample
//   STATUS_READY - status-word bit that flags a completed frame
//   STATUS_BANK  - status-word bit that names the completed bank
//   RD_LAT       - RAM read latency in clocks (strobe to valid data)
package mic_frame_pkg;

   localparam int SAMPLE_W     = 16;
   localparam int STATUS_READY = 0;
   localparam int STATUS_BANK  = 1;
   localparam int RD_LAT       = 2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT,
      S_CAPTURE,
      S_WR,
      S_SET_DONE,
      S_FLAG_WR,
      S_POLL_RD,
      S_POLL_W1,
      S_POLL_W2
   } state_t;

endpackage

// File: rtl/mic_frame_writer_valid_edge_sync.sv
// valid_edge_sync: brings the filter's level-type valid into the system clock
// domain through two flops and emits a one-clock pulse on each rising edge.
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   i_level - asynchronous level input
//   o_pulse - one-cycle pulse per synchronized rising edge
module valid_edge_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_level;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/mic_frame_writer.sv
// mic_frame_writer: packs decimated microphone sample sets into a ping-pong
// frame buffer in on-chip RAM, posts a status word plus IRQ per full frame and
// polls the status word for the CPU acknowledge while filling the other bank.
//   clk_clk        - system clock
//   reset_reset_n  - asynchronous active-low reset
//   smp_valid      - filter valid (level, other clock domain)
//   smp_data       - packed samples, mic i at [16i+15:16i]
//   ram_*          - Avalon-MM master toward the RAM's second slave port
//   irq            - frame-ready interrupt (level)
//   active_bank    - bank currently being filled
//   overrun_count  - saturating count of dropped sets and discarded frames
module mic_frame_writer
   import mic_frame_pkg::*;
#(
   parameter int MIC_N     = 2,
   parameter int FRAME_LEN = 64,
   parameter int ADDR_W    = 9
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic                      smp_valid,
   input  logic [SAMPLE_W*MIC_N-1:0] smp_data,
   output logic [ADDR_W-1:0]         ram_address,
   output logic                      ram_chipselect,
   output logic                      ram_write,
   output logic [31:0]               ram_writedata,
   output logic [3:0]                ram_byteenable,
   input  logic [31:0]               ram_readdata,
   output logic                      irq,
   output logic                      active_bank,
   output logic [15:0]               overrun_count
);

   localparam int WPS    = MIC_N / 2;
   localparam int FW     = FRAME_LEN * WPS;
   localparam int WIDX_W = (WPS > 1) ? $clog2(WPS) : 1;
   localparam int SIDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [ADDR_W-1:0] STATUS_ADDR = '1;

   state_t                    r_state;
   logic                      r_smp_flag;
   logic                      r_pending;
   logic                      r_irq;
   logic                      r_bank;
   logic [WIDX_W-1:0]         r_word_idx;
   logic [SIDX_W-1:0]         r_set_idx;
   logic [SAMPLE_W*MIC_N-1:0] r_hold;
   logic                      r_cs;
   logic                      r_wr;
   logic [ADDR_W-1:0]         r_addr;
   logic [31:0]               r_wdata;
   logic [15:0]               r_overrun_count;

   logic              w_edge;
   logic              w_word_last;
   logic              w_set_last;
   logic              w_drop;
   logic              w_frame_drop;
   logic [16:0]       w_ovr_sum;
   logic [15:0]       w_overrun_next;
   logic [ADDR_W-1:0] w_set_base;
   logic [WIDX_W-1:0] w_next_idx;
   logic [31:0]       w_status;
   logic              w_unused_rd;

   valid_edge_sync u_sync (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_level (smp_valid),
      .o_pulse (w_edge)
   );

   assign w_word_last = (r_word_idx == WIDX_W'(WPS - 1));
   assign w_set_last  = (r_set_idx == SIDX_W'(FRAME_LEN - 1));
   assign w_next_idx  = r_word_idx + 1'b1;
   assign w_set_base  = (r_bank ? ADDR_W'(FW) : '0)
                      + ADDR_W'(r_set_idx) * ADDR_W'(WPS);

   // An edge while the previous set is still unclaimed loses that set; an
   // edge in CAPTURE is a fresh set because the flag is being cleared.
   assign w_drop       = w_edge & r_smp_flag & (r_state != S_CAPTURE);
   assign w_frame_drop = (r_state == S_SET_DONE) & w_set_last & r_pending;

   // Both events can coincide, so sum in 17 bits before saturating.
   assign w_ovr_sum      = {1'b0, r_overrun_count} + {16'd0, w_drop}
                         + {16'd0, w_frame_drop};
   assign w_overrun_next = w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];

   always_comb begin
      w_status               = '0;
      w_status[STATUS_READY] = 1'b1;
      w_status[STATUS_BANK]  = r_bank;
   end

   // Only the ready bit matters to the poll.
   assign w_unused_rd = ^ram_readdata[31:1];

   // RAM strobes are registered: they are loaded on entry to WR, FLAG_WR and
   // POLL_RD so they are asserted exactly while the FSM sits in that state.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state         <= S_IDLE;
         r_smp_flag      <= 1'b0;
         r_pending       <= 1'b0;
         r_irq           <= 1'b0;
         r_bank          <= 1'b0;
         r_word_idx      <= '0;
         r_set_idx       <= '0;
         r_hold          <= '0;
         r_cs            <= 1'b0;
         r_wr            <= 1'b0;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_overrun_count <= '0;
      end else begin
         r_overrun_count <= w_overrun_next;

         if (w_edge) begin
            r_smp_flag <= 1'b1;
         end else if (r_state == S_CAPTURE) begin
            r_smp_flag <= 1'b0;
         end

         case (r_state)
            S_IDLE: r_state <= S_WAIT;

            S_WAIT: begin
               if (r_smp_flag) begin
                  r_state <= S_CAPTURE;
               end else if (r_pending) begin
                  r_cs    <= 1'b1;
                  r_wr    <= 1'b0;
                  r_addr  <= STATUS_ADDR;
                  r_state <= S_POLL_RD;
               end
            end

            S_CAPTURE: begin
               r_hold     <= smp_data;
               r_word_idx <= '0;
               r_cs       <= 1'b1;
               r_wr       <= 1'b1;
               r_addr     <= w_set_base;
               r_wdata    <= smp_data[31:0];
               r_state    <= S_WR;
            end

            S_WR: begin
               if (w_word_last) begin
                  r_cs    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_state <= S_SET_DONE;
               end else begin
                  r_word_idx <= w_next_idx;
                  r_addr     <= r_addr + 1'b1;
                  r_wdata    <= r_hold[32*int'(w_next_idx) +: 32];
               end
            end

            S_SET_DONE: begin
               if (!w_set_last) begin
                  r_set_idx <= r_set_idx + 1'b1;
                  r_state   <= S_WAIT;
               end else begin
                  r_set_idx <= '0;
                  if (r_pending) begin
                     // CPU still owns the other bank: refill this one.
                     r_state <= S_WAIT;
                  end else begin
                     r_cs    <= 1'b1;
                     r_wr    <= 1'b1;
                     r_addr  <= STATUS_ADDR;
                     r_wdata <= w_status;
                     r_state <= S_FLAG_WR;
                  end
               end
            end

            S_FLAG_WR: begin
               r_cs      <= 1'b0;
               r_wr      <= 1'b0;
               r_pending <= 1'b1;
               r_irq     <= 1'b1;
               r_bank    <= ~r_bank;
               r_state   <= S_WAIT;
            end

            S_POLL_RD: begin
               r_cs    <= 1'b0;
               r_state <= S_POLL_W1;
            end

            S_POLL_W1: r_state <= S_POLL_W2;

            S_POLL_W2: begin
               if (!ram_readdata[STATUS_READY]) begin
                  r_pending <= 1'b0;
                  r_irq     <= 1'b0;
               end
               r_state <= S_WAIT;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_address    = r_addr;
   assign ram_chipselect = r_cs;
   assign ram_write      = r_wr;
   assign ram_writedata  = r_wdata;
   assign ram_byteenable = 4'hF;
   assign irq            = r_irq;
   assign active_bank    = r_bank;
   assign overrun_count  = r_overrun_count;

endmodule

// File: tb/tb_mic_frame_writer.sv
// tb_mic_frame_writer: random sample sets against a frame-level reference
// model; expected RAM writes are queued at issue time and a negedge monitor
// compares every write the DUT performs. A small RAM model answers polls.
module tb_mic_frame_writer;
   import mic_frame_pkg::*;

   localparam int MIC_N     = 4;
   localparam int FRAME_LEN = 4;
   localparam int ADDR_W    = 9;
   localparam int WPS       = MIC_N / 2;
   localparam int FW        = FRAME_LEN * WPS;
   localparam logic [ADDR_W-1:0] STATUS_A = 9'h1FF;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk;
   logic              rst_n;
   logic              smp_valid;
   logic [63:0]       smp_data;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_chipselect;
   logic              ram_write;
   logic [31:0]       ram_writedata;
   logic [3:0]        ram_byteenable;
   logic [31:0]       ram_readdata;
   logic              irq;
   logic              active_bank;
   logic [15:0]       overrun_count;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] rd_pipe [RD_LAT];
   int          checks = 0;
   int          errors = 0;

   // reference model state: frame-level bookkeeping only
   int m_bank;
   int m_set;
   bit m_pending;
   int m_ovr;

   mic_frame_writer #(.MIC_N(MIC_N), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .smp_valid      (smp_valid),
      .smp_data       (smp_data),
      .ram_address    (ram_address),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_byteenable (ram_byteenable),
      .ram_readdata   (ram_readdata),
      .irq            (irq),
      .active_bank    (active_bank),
      .overrun_count  (overrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic ovr_inc();
      if (m_ovr < 16'hFFFF) m_ovr++;
   endtask

   // One accepted sample set: its words, and the frame-end bookkeeping.
   task automatic model_accept(input logic [63:0] d);
      wr_t w;
      for (int k = 0; k < WPS; k++) begin
         w.addr = ADDR_W'(m_bank*FW + m_set*WPS + k);
         w.data = {d[16*(2*k+1) +: 16], d[16*(2*k) +: 16]};
         exp_q.push_back(w);
      end
      m_set++;
      if (m_set == FRAME_LEN) begin
         m_set = 0;
         if (m_pending) begin
            ovr_inc();
         end else begin
            w.addr = STATUS_A;
            w.data = {30'd0, m_bank[0], 1'b1};
            exp_q.push_back(w);
            m_pending = 1'b1;
            m_bank    = 1 - m_bank;
         end
      end
   endtask

   // Write monitor plus RAM model with RD_LAT read latency.
   always @(negedge clk) begin
      if (rst_n && ram_chipselect && ram_write) begin
         mem[ram_address] = ram_writedata;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %h data %h, none expected",
                     ram_address, ram_writedata);
         end else begin
            mon_e = exp_q.pop_front();
            if (ram_address !== mon_e.addr || ram_writedata !== mon_e.data) begin
               errors++;
               $display("FAIL ram_write: got addr %h data %h expected addr %h data %h",
                        ram_address, ram_writedata, mon_e.addr, mon_e.data);
            end else begin
               $display("write addr %h data %h ok", ram_address, ram_writedata);
            end
         end
      end
      ram_readdata = rd_pipe[RD_LAT-1];
      for (int i = RD_LAT-1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = (ram_chipselect && !ram_write) ? mem[ram_address] : 32'hFFFF_FFFF;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_set(input logic [63:0] d, input int gap);
      smp_data  = d;
      smp_valid = 1'b1;
      model_accept(d);
      tick(6);
      smp_valid = 1'b0;
      tick(gap);
   endtask

   // Rising edges 3 cycles apart after a primer: the second lands while the
   // primer is being written (kept), the third while it is still unclaimed.
   task automatic send_triple(input logic [63:0] d);
      smp_data  = d;
      smp_valid = 1'b1;
      model_accept(d);
      tick(2);
      smp_valid = 1'b0;
      tick(1);
      smp_valid = 1'b1;
      model_accept(d);
      tick(2);
      smp_valid = 1'b0;
      tick(1);
      smp_valid = 1'b1;
      ovr_inc();
      tick(6);
      smp_valid = 1'b0;
      tick(20);
   endtask

   task automatic ack_and_wait();
      mem[STATUS_A] = 32'd0;
      m_pending = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!irq) break;
         tick(1);
      end
      chk("irq_after_ack", {31'd0, irq}, 32'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         tick(1);
      end
      chk("writes_drained", exp_q.size(), 32'd0);
      tick(10);
   endtask

   function automatic logic [63:0] rand_set();
      return {$urandom, $urandom};
   endfunction

   initial begin
      bit seen;
      logic [63:0] d;
      rst_n = 1'b0; smp_valid = 1'b0; smp_data = '0; ram_readdata = '0;
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
      m_bank = 0; m_set = 0; m_pending = 1'b0; m_ovr = 0;

      tick(3);
      chk("rst_chipselect", {31'd0, ram_chipselect}, 32'd0);
      chk("rst_write",      {31'd0, ram_write}, 32'd0);
      chk("rst_address",    {23'd0, ram_address}, 32'd0);
      chk("rst_writedata",  ram_writedata, 32'd0);
      chk("rst_byteenable", {28'd0, ram_byteenable}, 32'hF);
      chk("rst_irq",        {31'd0, irq}, 32'd0);
      chk("rst_bank",       {31'd0, active_bank}, 32'd0);
      chk("rst_overrun",    {16'd0, overrun_count}, 32'd0);
      rst_n = 1'b1;
      tick(5);

      // first frame into bank 0 with counting samples
      for (int n = 0; n < 4; n++)
         send_set({16'(4*n+4), 16'(4*n+3), 16'(4*n+2), 16'(4*n+1)}, 10);
      drain();
      chk("f1_irq",  {31'd0, irq}, 32'd1);
      chk("f1_bank", {31'd0, active_bank}, 32'd1);

      // second frame without acknowledge: discarded
      for (int n = 0; n < 4; n++) send_set(rand_set(), $urandom_range(8, 16));
      drain();
      chk("f2_overrun", {16'd0, overrun_count}, 32'(m_ovr));
      chk("f2_irq",     {31'd0, irq}, 32'd1);
      chk("f2_bank",    {31'd0, active_bank}, 32'd1);

      // acknowledge, then a frame into bank 1
      ack_and_wait();
      for (int n = 0; n < 4; n++) send_set(rand_set(), $urandom_range(8, 16));
      drain();
      chk("f3_bank", {31'd0, active_bank}, 32'd0);
      chk("f3_irq",  {31'd0, irq}, 32'd1);
      ack_and_wait();

      // closely spaced edges: one set dropped
      tick(10);
      send_triple(rand_set());
      drain();
      chk("triple_overrun", {16'd0, overrun_count}, 32'(m_ovr));

      // finish the frame so irq and bank are set, then reset mid-burst
      for (int n = 0; n < 2; n++) send_set(rand_set(), 12);
      drain();
      chk("pre_reset_irq", {31'd0, irq}, 32'd1);
      d = rand_set();
      smp_data  = d;
      smp_valid = 1'b1;
      model_accept(d);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ram_chipselect && ram_write) begin
            seen = 1'b1;
            break;
         end
      end
      chk("burst_seen", {31'd0, seen}, 32'd1);
      #1;
      rst_n     = 1'b0;
      smp_valid = 1'b0;
      #1;
      chk("async_rst_cs",      {31'd0, ram_chipselect}, 32'd0);
      chk("async_rst_irq",     {31'd0, irq}, 32'd0);
      chk("async_rst_bank",    {31'd0, active_bank}, 32'd0);
      chk("async_rst_overrun", {16'd0, overrun_count}, 32'd0);
      exp_q.delete();
      m_bank = 0; m_set = 0; m_pending = 1'b0; m_ovr = 0;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      send_set(rand_set(), 12);

      // saturation: preload near the top, then two more drops
      force dut.r_overrun_count = 16'hFFFE;
      tick(2);
      release dut.r_overrun_count;
      m_ovr = 16'hFFFE;
      send_triple(rand_set());
      chk("sat_first", {16'd0, overrun_count}, 32'(m_ovr));
      send_triple(rand_set());
      chk("sat_hold", {16'd0, overrun_count}, 32'hFFFF);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
